// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32 core: registers decoded operands/control,
// detects load-use hazards against the held instruction and inserts bubbles.
module id_ex_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_stall_i,
    input  logic             flush_i,
    input  logic             ID_valid_i,
    input  logic [31:0]      ID_PC_i,
    input  logic [31:0]      ID_RS1data_i,
    input  logic [31:0]      ID_RS2data_i,
    input  logic [31:0]      ID_Imm_i,
    input  logic [4:0]       ID_RS1_i,
    input  logic [4:0]       ID_RS2_i,
    input  logic [4:0]       ID_RD_i,
    input  logic [9:0]       ID_funct_i,
    input  logic [6:0]       ID_ctrl_i,
    output logic             EX_valid_o,
    output logic [31:0]      EX_PC_o,
    output logic [31:0]      EX_RS1data_o,
    output logic [31:0]      EX_RS2data_o,
    output logic [31:0]      EX_Imm_o,
    output logic [4:0]       EX_RS1_o,
    output logic [4:0]       EX_RS2_o,
    output logic [4:0]       EX_RD_o,
    output logic [9:0]       EX_funct_o,
    output logic [6:0]       EX_ctrl_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_FLUSH,
        ACT_HAZARD,
        ACT_LOAD
    } action_e;

    action_e          action;
    logic             hazard;

    logic             valid_q,  valid_d;
    logic [31:0]      pc_q,     pc_d;
    logic [31:0]      rs1data_q, rs1data_d;
    logic [31:0]      rs2data_q, rs2data_d;
    logic [31:0]      imm_q,    imm_d;
    logic [4:0]       rs1_q,    rs1_d;
    logic [4:0]       rs2_q,    rs2_d;
    logic [4:0]       rd_q,     rd_d;
    logic [9:0]       funct_q,  funct_d;
    logic [6:0]       ctrl_q,   ctrl_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // ctrl bit 4 is MemRead: only a real load with a non-x0 destination can cause a load-use stall
    assign hazard  = valid_q & ctrl_q[4] & (rd_q != 5'd0) & ID_valid_i &
                     ((rd_q == ID_RS1_i) | (rd_q == ID_RS2_i));
    assign stall_o = hazard & ~flush_i;

    always_comb begin
        action = ACT_LOAD;
        if (mem_stall_i)  action = ACT_HOLD;
        else if (flush_i) action = ACT_FLUSH;
        else if (hazard)  action = ACT_HAZARD;
    end

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs1data_d = rs1data_q;
        rs2data_d = rs2data_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        funct_d   = funct_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;

        if (action != ACT_HOLD) begin
            // bubble and invalid-ID loads both clear every field, including indices
            valid_d   = 1'b0;
            pc_d      = '0;
            rs1data_d = '0;
            rs2data_d = '0;
            imm_d     = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            funct_d   = '0;
            ctrl_d    = '0;
            if (action == ACT_LOAD && ID_valid_i) begin
                valid_d   = 1'b1;
                pc_d      = ID_PC_i;
                rs1data_d = ID_RS1data_i;
                rs2data_d = ID_RS2data_i;
                imm_d     = ID_Imm_i;
                rs1_d     = ID_RS1_i;
                rs2_d     = ID_RS2_i;
                rd_d      = ID_RD_i;
                funct_d   = ID_funct_i;
                ctrl_d    = ID_ctrl_i;
            end
        end

        if (action == ACT_HAZARD && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1data_q <= '0;
            rs2data_q <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            funct_q   <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1data_q <= rs1data_d;
            rs2data_q <= rs2data_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            funct_q   <= funct_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign EX_valid_o   = valid_q;
    assign EX_PC_o      = pc_q;
    assign EX_RS1data_o = rs1data_q;
    assign EX_RS2data_o = rs2data_q;
    assign EX_Imm_o     = imm_q;
    assign EX_RS1_o     = rs1_q;
    assign EX_RS2_o     = rs2_q;
    assign EX_RD_o      = rd_q;
    assign EX_funct_o   = funct_q;
    assign EX_ctrl_o    = ctrl_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver predicts each edge's outcome from the
// stage rules, a monitor compares stall_o and the registered EX state.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [9:0]  funct;
        logic [6:0]  ctrl;
    } ex_t;

    typedef struct {
        logic        stall;
        ex_t         st;
        int unsigned cnt;
    } exp_t;

    localparam logic [6:0] C_LW  = 7'b1110001;
    localparam logic [6:0] C_ADD = 7'b1000100;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_stall_i, flush_i, ID_valid_i;
    logic [31:0] ID_PC_i, ID_RS1data_i, ID_RS2data_i, ID_Imm_i;
    logic [4:0]  ID_RS1_i, ID_RS2_i, ID_RD_i;
    logic [9:0]  ID_funct_i;
    logic [6:0]  ID_ctrl_i;

    logic        EX_valid_o, EX_valid_2;
    logic [31:0] EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o;
    logic [31:0] EX_PC_2, EX_RS1data_2, EX_RS2data_2, EX_Imm_2;
    logic [4:0]  EX_RS1_o, EX_RS2_o, EX_RD_o, EX_RS1_2, EX_RS2_2, EX_RD_2;
    logic [9:0]  EX_funct_o, EX_funct_2;
    logic [6:0]  EX_ctrl_o, EX_ctrl_2;
    logic        stall_o, stall_2;
    logic [15:0] bubble_cnt_o;
    logic [1:0]  bubble_cnt_2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    exp_t        sb[$];
    ex_t         m;
    int unsigned mcnt;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
        .ID_valid_i(ID_valid_i), .ID_PC_i(ID_PC_i), .ID_RS1data_i(ID_RS1data_i),
        .ID_RS2data_i(ID_RS2data_i), .ID_Imm_i(ID_Imm_i), .ID_RS1_i(ID_RS1_i),
        .ID_RS2_i(ID_RS2_i), .ID_RD_i(ID_RD_i), .ID_funct_i(ID_funct_i), .ID_ctrl_i(ID_ctrl_i),
        .EX_valid_o(EX_valid_o), .EX_PC_o(EX_PC_o), .EX_RS1data_o(EX_RS1data_o),
        .EX_RS2data_o(EX_RS2data_o), .EX_Imm_o(EX_Imm_o), .EX_RS1_o(EX_RS1_o),
        .EX_RS2_o(EX_RS2_o), .EX_RD_o(EX_RD_o), .EX_funct_o(EX_funct_o), .EX_ctrl_o(EX_ctrl_o),
        .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
        .ID_valid_i(ID_valid_i), .ID_PC_i(ID_PC_i), .ID_RS1data_i(ID_RS1data_i),
        .ID_RS2data_i(ID_RS2data_i), .ID_Imm_i(ID_Imm_i), .ID_RS1_i(ID_RS1_i),
        .ID_RS2_i(ID_RS2_i), .ID_RD_i(ID_RD_i), .ID_funct_i(ID_funct_i), .ID_ctrl_i(ID_ctrl_i),
        .EX_valid_o(EX_valid_2), .EX_PC_o(EX_PC_2), .EX_RS1data_o(EX_RS1data_2),
        .EX_RS2data_o(EX_RS2data_2), .EX_Imm_o(EX_Imm_2), .EX_RS1_o(EX_RS1_2),
        .EX_RS2_o(EX_RS2_2), .EX_RD_o(EX_RD_2), .EX_funct_o(EX_funct_2), .EX_ctrl_o(EX_ctrl_2),
        .stall_o(stall_2), .bubble_cnt_o(bubble_cnt_2)
    );

    function automatic ex_t dut_state();
        return {EX_valid_o, EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o,
                EX_RS1_o, EX_RS2_o, EX_RD_o, EX_funct_o, EX_ctrl_o};
    endfunction

    function automatic ex_t sat_state();
        return {EX_valid_2, EX_PC_2, EX_RS1data_2, EX_RS2data_2, EX_Imm_2,
                EX_RS1_2, EX_RS2_2, EX_RD_2, EX_funct_2, EX_ctrl_2};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string name, input ex_t act, input ex_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        ex_t a;
        a = dut_state();
        chk("EX_valid", 32'(a.valid), 32'(e.st.valid));
        chk("EX_PC", a.pc, e.st.pc);
        chk("EX_RS1data", a.rs1d, e.st.rs1d);
        chk("EX_RS2data", a.rs2d, e.st.rs2d);
        chk("EX_Imm", a.imm, e.st.imm);
        chk("EX_RS1", 32'(a.rs1), 32'(e.st.rs1));
        chk("EX_RS2", 32'(a.rs2), 32'(e.st.rs2));
        chk("EX_RD", 32'(a.rd), 32'(e.st.rd));
        chk("EX_funct", 32'(a.funct), 32'(e.st.funct));
        chk("EX_ctrl", 32'(a.ctrl), 32'(e.st.ctrl));
        chk("bubble_cnt", 32'(bubble_cnt_o), (e.cnt > 65535) ? 32'd65535 : e.cnt);
        chk("bubble_cnt_sat", 32'(bubble_cnt_2), (e.cnt > 3) ? 32'd3 : e.cnt);
        chk_state("sat_state", sat_state(), e.st);
    endtask

    // Reference: decide the edge outcome from the rules and push the prediction.
    task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic [6:0] ctrl,
                        input logic fl, input logic ms);
        exp_t e;
        ex_t  nx;
        logic hz;
        logic [31:0] d1, d2, imm;
        logic [9:0]  fn;
        d1  = $urandom;
        d2  = $urandom;
        imm = $urandom;
        fn  = 10'($urandom);
        @(negedge clk);
        ID_valid_i = v; ID_PC_i = pc; ID_RS1_i = r1; ID_RS2_i = r2; ID_RD_i = rd;
        ID_ctrl_i = ctrl; flush_i = fl; mem_stall_i = ms;
        ID_RS1data_i = d1; ID_RS2data_i = d2; ID_Imm_i = imm; ID_funct_i = fn;
        hz = m.valid && m.ctrl[4] && m.rd != 5'd0 && v && (m.rd == r1 || m.rd == r2);
        e.stall = hz && !fl;
        if (ms)             nx = m;
        else if (fl || hz || !v) nx = '0;
        else                nx = {1'b1, pc, d1, d2, imm, r1, r2, rd, fn, ctrl};
        if (!ms && !fl && hz) mcnt++;
        m     = nx;
        e.st  = nx;
        e.cnt = mcnt;
        sb.push_back(e);
    endtask

    task automatic chk_reset_zero();
        chk_state("reset_state", dut_state(), '0);
        chk_state("reset_state_sat", sat_state(), '0);
        chk("reset_cnt", 32'(bubble_cnt_o), 32'd0);
        chk("reset_cnt_sat", 32'(bubble_cnt_2), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        ID_valid_i = 1'b1; flush_i = 1'b0; mem_stall_i = 1'b0;
        #3 rst_i = 1'b0;
        #1 chk_reset_zero();
        m = '0;
        mcnt = 0;
        @(posedge clk);
        #2 rst_i = 1'b1;
        step(1'b1, 32'h10, 5'd1, 5'd2, 5'd3, C_ADD, 1'b0, 1'b0);
    endtask

    task automatic rand_step();
        logic [6:0] c;
        c = 7'($urandom);
        c[4] = ($urandom_range(0, 1) == 1);
        step($urandom_range(0, 9) < 8, $urandom, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), c,
             $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                chk("stall_o", 32'(stall_o), 32'(sb[0].stall));
                chk("stall_sat", 32'(stall_2), 32'(sb[0].stall));
            end
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst_i = 1'b0;
        mem_stall_i = 1'b0; flush_i = 1'b0; ID_valid_i = 1'b0;
        ID_PC_i = '0; ID_RS1data_i = '0; ID_RS2data_i = '0; ID_Imm_i = '0;
        ID_RS1_i = '0; ID_RS2_i = '0; ID_RD_i = '0; ID_funct_i = '0; ID_ctrl_i = '0;
        m = '0;
        mcnt = 0;
        #1 chk_reset_zero();
        @(posedge clk);
        #2 rst_i = 1'b1;

        // load-use: lw x5 then add x6,x5,x7 held for the bubble cycle
        step(1'b1, 32'h100, 5'd1, 5'd0, 5'd5, C_LW, 1'b0, 1'b0);
        step(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, C_ADD, 1'b0, 1'b0);
        step(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, C_ADD, 1'b0, 1'b0);
        // no false hazard: lw x0, then non-load producer of x5
        step(1'b1, 32'h200, 5'd1, 5'd0, 5'd0, C_LW, 1'b0, 1'b0);
        step(1'b1, 32'h204, 5'd0, 5'd0, 5'd6, C_ADD, 1'b0, 1'b0);
        step(1'b1, 32'h208, 5'd1, 5'd2, 5'd5, C_ADD, 1'b0, 1'b0);
        step(1'b1, 32'h20c, 5'd5, 5'd5, 5'd6, C_ADD, 1'b0, 1'b0);
        // flush wins over hazard
        step(1'b1, 32'h300, 5'd1, 5'd0, 5'd5, C_LW, 1'b0, 1'b0);
        step(1'b1, 32'h304, 5'd5, 5'd7, 5'd6, C_ADD, 1'b1, 1'b0);
        // memory stall over a hazard, then release
        step(1'b1, 32'h400, 5'd1, 5'd0, 5'd5, C_LW, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h404 + 32'(i), 5'd7, 5'd5, 5'd6, C_ADD, 1'b0, 1'b1);
        step(1'b1, 32'h404, 5'd7, 5'd5, 5'd6, C_ADD, 1'b0, 1'b0);
        step(1'b1, 32'h404, 5'd7, 5'd5, 5'd6, C_ADD, 1'b0, 1'b0);
        // five more load-use pairs to drive the 2-bit counter into saturation
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h500, 5'd1, 5'd0, 5'd9, C_LW, 1'b0, 1'b0);
            step(1'b1, 32'h504, 5'd9, 5'd3, 5'd4, C_ADD, 1'b0, 1'b0);
            step(1'b1, 32'h504, 5'd9, 5'd3, 5'd4, C_ADD, 1'b0, 1'b0);
        end

        mid_reset();

        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) mid_reset();
            else rand_step();
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage RV32 core. It registers decoded operands and control from ID and presents EX_RS1_o/EX_RS2_o to the EX-stage forwarding unit. It detects load-use hazards against the instruction it holds and inserts bubbles, honours branch flush and the data-memory stall, and keeps a saturating bubble counter.

## Interface
- CNT_W, 16: width of bubble_cnt_o.
- clk_i  in  1  core clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_stall_i  in  1  data-memory/cache stall; freeze whole stage.
- flush_i  in  1  branch taken in ID; squash incoming instruction.
- ID_valid_i  in  1  ID holds a real instruction.
- ID_PC_i  in  32  PC of ID instruction.
- ID_RS1data_i  in  32  register-file read data, rs1.
- ID_RS2data_i  in  32  register-file read data, rs2.
- ID_Imm_i  in  32  sign-extended immediate.
- ID_RS1_i, ID_RS2_i  in  5 each  source register indices.
- ID_RD_i  in  5  destination register index.
- ID_funct_i  in  10  {funct7, funct3}.
- ID_ctrl_i  in  7  {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc}, bit 6 down to 0.
- EX_valid_o  out  1  EX instruction is real.
- EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o  out  32 each  registered copies.
- EX_RS1_o, EX_RS2_o, EX_RD_o  out  5 each  registered indices (to forwarding unit).
- EX_funct_o  out  10  registered funct.
- EX_ctrl_o  out  7  registered control, same bit map.
- stall_o  out  1  load-use hazard; PC and IF/ID must hold this cycle.
- bubble_cnt_o  out  CNT_W  number of load-use bubbles inserted.

## Operation
- hazard = EX_valid_o & EX_ctrl_o[4] & (EX_RD_o != 0) & ID_valid_i & ((EX_RD_o == ID_RS1_i) | (EX_RD_o == ID_RS2_i)).
- stall_o = hazard & ~flush_i; combinational from registered state and ID inputs; independent of mem_stall_i.
- Per-edge action, priority order:
  1. mem_stall_i = 1: HOLD, all registers and counter unchanged.
  2. flush_i = 1: BUBBLE.
  3. hazard = 1: BUBBLE, bubble_cnt_o += 1.
  4. otherwise: LOAD all EX_* from ID_*; EX_valid_o = ID_valid_i.
- BUBBLE: EX_valid_o=0, EX_ctrl_o=0, EX_RD_o=0, EX_RS1_o=0, EX_RS2_o=0, all data fields, PC and funct = 0 (x0 indices guarantee no forwarding match).
- LOAD with ID_valid_i=0 loads the bubble values, not the ID data.
- bubble_cnt_o saturates at 2^CNT_W-1; flush bubbles are not counted.
- A bubble just inserted has MemRead=0, so a single load-use costs exactly one bubble.

## Timing
- Reset (rst_i low, immediate, no clock needed): every EX_* output 0, EX_valid_o 0, bubble_cnt_o 0; stall_o therefore 0.
- Latency: ID inputs visible on EX_* one cycle after the capturing edge.
- Reset asserted mid-operation: instruction in stage discarded, counter cleared; first edge after rst_i rises performs a normal LOAD.
- Simultaneous flush_i and hazard: bubble, stall_o 0, counter unchanged.
- Simultaneous mem_stall_i and hazard: stall_o 1, stage held, counter unchanged; bubble inserted on first edge with mem_stall_i low.
- Hazard with EX_RD_o = 0 or EX_valid_o = 0 never stalls.

## Test plan
- Reset: drive rst_i low mid-run with ID_valid_i=1 -> all outputs 0 immediately, bubble_cnt_o=0; after release, next edge loads ID_PC_i=0x10 to EX_PC_o.
- Load-use: EX holds lw x5 (ctrl MemRead=1, RD=5), ID add x6,x5,x7 -> stall_o=1 same cycle; next edge EX_valid_o=0, EX_ctrl_o=0, bubble_cnt_o=1; following edge add loaded, stall_o=0.
- No false hazard: EX lw x0 or EX add x5 (MemRead=0), ID uses x5 -> stall_o=0, instruction loaded next edge.
- Flush priority: hazard active and flush_i=1 -> stall_o=0, bubble inserted, bubble_cnt_o unchanged.
- Memory stall: mem_stall_i=1 for 3 cycles with new ID values and hazard -> EX_* and counter frozen, stall_o=1; on release one bubble, bubble_cnt_o+1.
- Saturation: CNT_W=2, force 5 load-use bubbles -> bubble_cnt_o stops at 3.
